// File: rtl/demux_pkg.sv
// Shared types and helpers for the 1-to-N stream demultiplexer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package demux_pkg;

    localparam int DEMUX_N_OUT_MAX = 64;

    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_t;

    // True when a select value names an existing channel.
    function automatic logic sel_in_range(input logic [31:0] sel, input logic [31:0] n);
        return (sel < n);
    endfunction

endpackage

// File: rtl/demux_slot.sv
// One-entry output slot for a single demux channel (EMPTY/FULL).
// Latency: load -> valid one cycle.
// Backpressure: holds data while FULL until drain; same-cycle load overrides drain.
module demux_slot
    import demux_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int ZERO_IDLE = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              load,
    input  logic [DATA_W-1:0] load_data,
    input  logic              drain,
    output logic              valid,
    output logic [DATA_W-1:0] data
);

    slot_state_t       state_q;
    slot_state_t       state_d;
    logic [DATA_W-1:0] data_q;

    // Slot occupancy register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= SLOT_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Next occupancy: flush beats load, load beats drain.
    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = SLOT_EMPTY;
        end else if (load) begin
            state_d = SLOT_FULL;
        end else if ((state_q == SLOT_FULL) && drain) begin
            state_d = SLOT_EMPTY;
        end
    end

    // Payload capture; kept across drain so the non-masked variant can show the last word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q <= '0;
        end else if (load && !flush) begin
            data_q <= load_data;
        end
    end

    assign valid = (state_q == SLOT_FULL);

    generate
        if (ZERO_IDLE != 0) begin : g_zero_idle
            assign data = valid ? data_q : '0;
        end else begin : g_hold_idle
            assign data = data_q;
        end
    endgenerate

endmodule

// File: rtl/demux_1ton_stream.sv
// 1-to-N valid/ready stream demux with a registered one-entry slot per channel.
// Latency: accepted word appears on its channel one cycle later; 1 word/cycle throughput.
// Backpressure: in_ready follows only the selected channel's slot; bad selects always accepted and dropped.
module demux_1ton_stream
    import demux_pkg::*;
#(
    parameter int N_OUT     = 16,
    parameter int DATA_W    = 8,
    parameter int SEL_W     = $clog2(N_OUT),
    parameter int CNT_W     = 16,
    parameter int ZERO_IDLE = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    flush,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [DATA_W-1:0]       in_data,
    input  logic [SEL_W-1:0]        in_sel,
    output logic [N_OUT-1:0]        out_valid,
    input  logic [N_OUT-1:0]        out_ready,
    output logic [N_OUT*DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]        bad_sel_cnt
);

    generate
        if (N_OUT < 2 || N_OUT > DEMUX_N_OUT_MAX) begin : g_bad_n_out
            $error("demux_1ton_stream: N_OUT out of supported range");
        end
    endgenerate

    logic             sel_ok;
    logic             accept;
    logic             drop;
    logic [N_OUT-1:0] sel_onehot;
    logic [N_OUT-1:0] load_vec;

    assign sel_ok = sel_in_range(32'(in_sel), N_OUT);

    // Decode the select into a one-hot channel vector (all zero when out of range).
    always_comb begin
        sel_onehot = '0;
        for (int k = 0; k < N_OUT; k++) begin
            sel_onehot[k] = (32'(in_sel) == 32'(k));
        end
    end

    // Ready depends only on the presented channel; out-of-range words are always sunk.
    always_comb begin
        in_ready = 1'b0;
        if (!flush) begin
            if (!sel_ok) begin
                in_ready = 1'b1;
            end else begin
                in_ready = |(sel_onehot & (~out_valid | out_ready));
            end
        end
    end

    assign accept   = in_valid & in_ready;
    assign load_vec = sel_onehot & {N_OUT{accept}};
    assign drop     = accept & ~sel_ok;

    // Saturating count of words dropped for an out-of-range select.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bad_sel_cnt <= '0;
        end else if (drop && (bad_sel_cnt != {CNT_W{1'b1}})) begin
            bad_sel_cnt <= bad_sel_cnt + CNT_W'(1);
        end
    end

    generate
        for (genvar k = 0; k < N_OUT; k++) begin : g_slot
            demux_slot #(
                .DATA_W    (DATA_W),
                .ZERO_IDLE (ZERO_IDLE)
            ) u_slot (
                .clk       (clk),
                .rst_n     (rst_n),
                .flush     (flush),
                .load      (load_vec[k]),
                .load_data (in_data),
                .drain     (out_ready[k]),
                .valid     (out_valid[k]),
                .data      (out_data[k*DATA_W +: DATA_W])
            );
        end
    endgenerate

endmodule

// File: tb/tb_demux_1ton_stream.sv
// Self-checking bench: 16-channel zero-idle instance against a behavioural slot model,
// plus a 10-channel hold-idle instance with a 2-bit drop counter for bad selects.
module tb_demux_1ton_stream;

    logic clk;
    logic rst_n;

    // Instance A: N_OUT=16, ZERO_IDLE=1
    logic         a_flush, a_in_valid, a_in_ready;
    logic [7:0]   a_in_data;
    logic [3:0]   a_in_sel;
    logic [15:0]  a_out_valid, a_out_ready;
    logic [127:0] a_out_data;
    logic [15:0]  a_cnt;

    // Instance B: N_OUT=10, SEL_W=4, CNT_W=2, ZERO_IDLE=0
    logic         b_flush, b_in_valid, b_in_ready;
    logic [7:0]   b_in_data;
    logic [3:0]   b_in_sel;
    logic [9:0]   b_out_valid, b_out_ready;
    logic [79:0]  b_out_data;
    logic [1:0]   b_cnt;

    int checks;
    int errors;

    // Reference model for instance A: occupancy and contents per channel.
    bit         mv [16];
    logic [7:0] md [16];
    logic       r;

    demux_1ton_stream #(
        .N_OUT(16), .DATA_W(8), .SEL_W(4), .CNT_W(16), .ZERO_IDLE(1)
    ) dut_a (
        .clk(clk), .rst_n(rst_n), .flush(a_flush),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data), .in_sel(a_in_sel),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
        .bad_sel_cnt(a_cnt)
    );

    demux_1ton_stream #(
        .N_OUT(10), .DATA_W(8), .SEL_W(4), .CNT_W(2), .ZERO_IDLE(0)
    ) dut_b (
        .clk(clk), .rst_n(rst_n), .flush(b_flush),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data), .in_sel(b_in_sel),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
        .bad_sel_cnt(b_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_a_outputs();
        logic [15:0]  ev;
        logic [127:0] ed;
        ev = '0;
        ed = '0;
        for (int k = 0; k < 16; k++) begin
            ev[k] = mv[k];
            ed[k*8 +: 8] = mv[k] ? md[k] : 8'h00;
        end
        chk("a_out_valid", 128'(a_out_valid), 128'(ev));
        chk("a_out_data", a_out_data, ed);
        chk("a_bad_sel_cnt", 128'(a_cnt), 128'(0));
    endtask

    // One cycle on instance A, entered and left at a falling edge.
    task automatic step_a(input logic v, input logic [3:0] s, input logic [7:0] d,
                          input logic [15:0] rdy, input logic f, output logic rdy_seen);
        logic exp_rdy;
        a_in_valid  = v;
        a_in_sel    = s;
        a_in_data   = d;
        a_out_ready = rdy;
        a_flush     = f;
        #1;
        exp_rdy  = f ? 1'b0 : (!mv[s] || rdy[s]);
        rdy_seen = a_in_ready;
        chk("a_in_ready", 128'(a_in_ready), 128'(exp_rdy));
        check_a_outputs();
        @(posedge clk);
        if (f) begin
            for (int k = 0; k < 16; k++) mv[k] = 1'b0;
        end else begin
            for (int k = 0; k < 16; k++) if (mv[k] && rdy[k]) mv[k] = 1'b0;
            if (v && exp_rdy) begin
                mv[s] = 1'b1;
                md[s] = d;
            end
        end
        @(negedge clk);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        clk = 1'b0;
        rst_n = 1'b0;
        a_flush = 0; a_in_valid = 0; a_in_data = 0; a_in_sel = 0; a_out_ready = 0;
        b_flush = 0; b_in_valid = 0; b_in_data = 0; b_in_sel = 0; b_out_ready = 0;
        for (int k = 0; k < 16; k++) begin
            mv[k] = 1'b0;
            md[k] = 8'h00;
        end

        #1;
        chk("rst_a_valid", 128'(a_out_valid), 128'(0));
        chk("rst_a_cnt", 128'(a_cnt), 128'(0));
        chk("rst_b_valid", 128'(b_out_valid), 128'(0));
        chk("rst_b_data", 128'(b_out_data), 128'(0));
        chk("rst_b_cnt", 128'(b_cnt), 128'(0));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Routing sweep, all consumers ready, back-to-back.
        for (int k = 0; k < 16; k++) begin
            step_a(1'b1, 4'(k), 8'(8'hA0 + k), 16'hFFFF, 1'b0, r);
            chk("sweep_in_ready", 128'(r), 128'(1));
            chk("sweep_valid", 128'(a_out_valid[k]), 128'(1));
            chk("sweep_data", 128'(a_out_data[k*8 +: 8]), 128'(8'hA0 + k));
        end
        step_a(1'b0, 4'd0, 8'h00, 16'hFFFF, 1'b0, r);
        chk("sweep_drained_data15", 128'(a_out_data[15*8 +: 8]), 128'(0));

        // Back-pressure on channel 7.
        step_a(1'b1, 4'd7, 8'h11, 16'hFF7F, 1'b0, r);
        chk("bp_first_acc", 128'(r), 128'(1));
        step_a(1'b1, 4'd7, 8'h22, 16'hFF7F, 1'b0, r);
        chk("bp_stall", 128'(r), 128'(0));
        chk("bp_hold", 128'(a_out_data[7*8 +: 8]), 128'(8'h11));
        step_a(1'b1, 4'd2, 8'h33, 16'hFF7F, 1'b0, r);
        chk("bp_other_ch", 128'(r), 128'(1));
        chk("bp_hold2", 128'(a_out_data[7*8 +: 8]), 128'(8'h11));
        step_a(1'b1, 4'd7, 8'h22, 16'hFFFF, 1'b0, r);
        chk("bp_drain_load_rdy", 128'(r), 128'(1));
        chk("bp_drain_load_vld", 128'(a_out_valid[7]), 128'(1));
        chk("bp_drain_load_dat", 128'(a_out_data[7*8 +: 8]), 128'(8'h22));
        step_a(1'b0, 4'd0, 8'h00, 16'hFFFF, 1'b0, r);

        // Flush with a word presented.
        step_a(1'b1, 4'd0, 8'hC0, 16'h0000, 1'b0, r);
        step_a(1'b1, 4'd9, 8'hC9, 16'h0000, 1'b0, r);
        chk("fl_pre", 128'(a_out_valid), 128'(16'h0201));
        step_a(1'b1, 4'd4, 8'hC4, 16'h0000, 1'b1, r);
        chk("fl_in_ready", 128'(r), 128'(0));
        chk("fl_all_empty", 128'(a_out_valid), 128'(0));
        step_a(1'b0, 4'd0, 8'h00, 16'h0000, 1'b0, r);

        // Randomised traffic against the model.
        repeat (400) begin
            step_a(1'($urandom), 4'($urandom_range(0, 15)), 8'($urandom),
                   16'($urandom) | 16'($urandom), 1'($urandom_range(0, 15) == 0), r);
        end

        // Asynchronous reset mid-stream with slots 3 and 5 full.
        step_a(1'b0, 4'd0, 8'h00, 16'hFFFF, 1'b0, r);
        step_a(1'b1, 4'd3, 8'h33, 16'h0000, 1'b0, r);
        step_a(1'b1, 4'd5, 8'h55, 16'h0000, 1'b0, r);
        chk("mid_pre", 128'(a_out_valid), 128'(16'h0028));
        a_in_valid = 1'b1;
        a_in_sel = 4'd9;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 128'(a_out_valid), 128'(0));
        chk("mid_rst_data", a_out_data, 128'(0));
        chk("mid_rst_cnt", 128'(a_cnt), 128'(0));
        a_in_valid = 1'b0;
        for (int k = 0; k < 16; k++) begin
            mv[k] = 1'b0;
            md[k] = 8'h00;
        end
        @(negedge clk);
        rst_n = 1'b1;
        step_a(1'b0, 4'd0, 8'h00, 16'h0000, 1'b0, r);

        // Instance B: out-of-range selects are sunk and counted, saturating at 3.
        b_out_ready = '1;
        b_in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            logic [3:0] bs [5];
            bs = '{4'd12, 4'd13, 4'd15, 4'd10, 4'd11};
            b_in_sel  = bs[i];
            b_in_data = 8'(8'hE0 + i);
            #1;
            chk("b_bad_in_ready", 128'(b_in_ready), 128'(1));
            @(posedge clk);
            @(negedge clk);
            chk("b_bad_no_valid", 128'(b_out_valid), 128'(0));
            chk("b_bad_cnt", 128'(b_cnt), 128'((i < 3) ? i + 1 : 3));
        end
        b_flush = 1'b1;
        b_in_sel = 4'd14;
        #1;
        chk("b_flush_in_ready", 128'(b_in_ready), 128'(0));
        @(posedge clk);
        @(negedge clk);
        b_flush = 1'b0;
        chk("b_flush_cnt", 128'(b_cnt), 128'(3));

        // Instance B holds the last word on an idle channel.
        b_out_ready = '0;
        b_in_sel = 4'd5;
        b_in_data = 8'h5A;
        #1;
        chk("b_load_rdy", 128'(b_in_ready), 128'(1));
        @(posedge clk);
        @(negedge clk);
        b_in_valid = 1'b0;
        chk("b_load_vld", 128'(b_out_valid), 128'(10'h020));
        chk("b_load_dat", 128'(b_out_data[5*8 +: 8]), 128'(8'h5A));
        b_out_ready[5] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("b_drained_vld", 128'(b_out_valid), 128'(0));
        chk("b_hold_idle_dat", 128'(b_out_data[5*8 +: 8]), 128'(8'h5A));

        // Instance A masks an idle channel to zero.
        step_a(1'b1, 4'd5, 8'h5A, 16'h0000, 1'b0, r);
        chk("a_load5", 128'(a_out_data[5*8 +: 8]), 128'(8'h5A));
        step_a(1'b0, 4'd0, 8'h00, 16'h0020, 1'b0, r);
        chk("a_zero_idle_dat", 128'(a_out_data[5*8 +: 8]), 128'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
